trng_seed_controller: RTL and testbench

TRNG_SEED_CONTROLLER -- requirements
Module: trng_seed_controller

---
 rtl/trng_pkg.sv | 16 +
 rtl/trng_rep_counter.sv | 43 ++++
 rtl/trng_seed_controller.sv | 114 +++++++++++
 tb/tb_trng_seed_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// TRNG seed controller shared types and defaults.
// State encoding plus default word, timeout and health limits.
package trng_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_PRESENT,
    S_FAIL
  } state_t;

  localparam int WORD_W_DEF     = 32;
  localparam int MAX_CYCLES_DEF = 1024;
  localparam int REP_LIMIT_DEF  = 16;

endpackage

// File: rtl/trng_rep_counter.sv
// Repetition-count health test on corrected entropy bits.
// trip flags the accepted bit that completes REP_LIMIT equal bits in a row.
module trng_rep_counter #(
  parameter int REP_LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic valid,
  input  logic data,
  output logic trip
);

  localparam int CW = $clog2(REP_LIMIT) + 1;
  localparam logic [CW-1:0] LIM = CW'(REP_LIMIT);

  logic [CW-1:0] run;
  logic [CW-1:0] run_nxt;
  logic          last;

  // run==0 means no bit seen since clear, so any bit starts a new run
  always_comb begin
    run_nxt = CW'(1);
    if (run != '0 && data == last)
      run_nxt = (run >= LIM) ? run : run + 1'b1;
  end

  assign trip = valid && (run_nxt >= LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run  <= '0;
      last <= 1'b0;
    end else if (clear) begin
      run  <= '0;
      last <= 1'b0;
    end else if (valid) begin
      run  <= run_nxt;
      last <= data;
    end
  end

endmodule

// File: rtl/trng_seed_controller.sv
// Collects Von Neumann corrected bits into seed words with
// timeout supervision and a repetition-count health test.
module trng_seed_controller
  import trng_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              vn_enable,
  input  logic              vn_valid,
  input  logic              vn_bit,
  output logic              seed_valid,
  input  logic              seed_ready,
  output logic [WORD_W-1:0] seed_data,
  output logic              busy,
  output logic              timeout,
  output logic              health_fail,
  input  logic              clear_fail
);

  localparam int BW = $clog2(WORD_W) + 1;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(MAX_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-2:0] shreg;
  logic [WORD_W-1:0] shreg_nxt;
  logic [BW-1:0]     bit_cnt;
  logic [CW-1:0]     cyc_cnt;

  logic collect;
  logic accept;
  logic complete;
  logic expire;
  logic handshake;
  logic launch;
  logic trip;

  assign collect   = (state == S_COLLECT);
  assign accept    = collect && vn_valid;
  assign complete  = accept && (bit_cnt == BIT_LAST);
  assign expire    = collect && (cyc_cnt == CYC_LAST) && !complete;
  assign handshake = (state == S_PRESENT) && seed_ready;
  assign launch    = start && ((state == S_IDLE) || handshake);
  assign shreg_nxt = {shreg, vn_bit};

  assign vn_enable   = collect;
  assign seed_valid  = (state == S_PRESENT);
  assign busy        = collect || seed_valid;
  assign health_fail = (state == S_FAIL);
  assign timeout     = expire && !trip;

  trng_rep_counter #(
    .REP_LIMIT (REP_LIMIT)
  ) u_rep (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (launch),
    .valid   (accept),
    .data    (vn_bit),
    .trip    (trip)
  );

  // health trip outranks completion, completion outranks timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (trip)          state_nxt = S_FAIL;
        else if (complete) state_nxt = S_PRESENT;
        else if (expire)   state_nxt = S_IDLE;
      end
      S_PRESENT: if (seed_ready)
        state_nxt = start ? S_COLLECT : S_IDLE;
      S_FAIL:    if (clear_fail) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      cyc_cnt   <= '0;
      seed_data <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        shreg   <= '0;
        bit_cnt <= '0;
        cyc_cnt <= '0;
      end else if (collect) begin
        if (cyc_cnt != CYC_LAST)
          cyc_cnt <= cyc_cnt + 1'b1;
        if (accept) begin
          shreg <= shreg_nxt[WORD_W-2:0];
          if (bit_cnt != BIT_LAST)
            bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (complete && !trip)
        seed_data <= shreg_nxt;
    end
  end

endmodule

// File: tb/tb_trng_seed_controller.sv
// Bench for trng_seed_controller: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_trng_seed_controller;

  localparam int W  = 8;
  localparam int MC = 16;
  localparam int RL = 4;

  localparam int M_IDLE = 0;
  localparam int M_COL  = 1;
  localparam int M_PRE  = 2;
  localparam int M_FAIL = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         vn_valid = 1'b0;
  logic         vn_bit = 1'b0;
  logic         seed_ready = 1'b0;
  logic         clear_fail = 1'b0;
  logic         vn_enable;
  logic         seed_valid;
  logic [W-1:0] seed_data;
  logic         busy;
  logic         timeout;
  logic         health_fail;

  int errors = 0;
  int checks = 0;

  int m_mode = M_IDLE;
  int q[$];
  int m_cyc = 0;
  logic [W-1:0] m_data = '0;
  int cyc_no = 0;
  int to_seen = 0;
  int to_cyc = 0;

  trng_seed_controller #(
    .WORD_W     (W),
    .MAX_CYCLES (MC),
    .REP_LIMIT  (RL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .vn_enable   (vn_enable),
    .vn_valid    (vn_valid),
    .vn_bit      (vn_bit),
    .seed_valid  (seed_valid),
    .seed_ready  (seed_ready),
    .seed_data   (seed_data),
    .busy        (busy),
    .timeout     (timeout),
    .health_fail (health_fail),
    .clear_fail  (clear_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    q.delete();
    m_cyc = 0;
    m_data = '0;
  endtask

  function automatic int tail_run();
    int n = 1;
    for (int i = q.size() - 1; i > 0 && q[i] == q[i-1]; i--)
      n++;
    return n;
  endfunction

  // compare at negedge against the model, then advance the model
  task automatic tick();
    bit m_trip;
    bit m_done;
    bit m_to;
    int run;
    int acc;
    @(negedge clk);
    cyc_no++;
    m_trip = 0;
    m_done = 0;
    m_to = 0;
    if (reset_n && m_mode == M_COL) begin
      if (vn_valid) begin
        run = (q.size() > 0 && q[q.size()-1] == int'(vn_bit))
            ? tail_run() + 1 : 1;
        m_trip = (run >= RL);
        m_done = (q.size() + 1 == W);
      end
      m_to = !m_trip && !m_done && (m_cyc == MC - 1);
    end
    check("vn_enable", vn_enable, reset_n && m_mode == M_COL);
    check("seed_valid", seed_valid, reset_n && m_mode == M_PRE);
    check("busy", busy,
          reset_n && (m_mode == M_COL || m_mode == M_PRE));
    check("health_fail", health_fail, reset_n && m_mode == M_FAIL);
    check("timeout", timeout, m_to);
    check("seed_data", seed_data, reset_n ? m_data : '0);
    if (timeout) begin
      to_seen++;
      to_cyc = cyc_no;
    end
    if (!reset_n) begin
      model_reset();
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          m_mode = M_COL;
          q.delete();
          m_cyc = 0;
        end
        M_COL: begin
          if (vn_valid) q.push_back(int'(vn_bit));
          if (m_trip) m_mode = M_FAIL;
          else if (m_done) begin
            acc = 0;
            foreach (q[i]) acc = acc * 2 + q[i];
            m_data = W'(acc);
            m_mode = M_PRE;
          end else if (m_to) m_mode = M_IDLE;
          else m_cyc++;
        end
        M_PRE: if (seed_ready) begin
          if (start) begin
            m_mode = M_COL;
            q.delete();
            m_cyc = 0;
          end else m_mode = M_IDLE;
        end
        default: if (clear_fail) m_mode = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    logic [W-1:0] v;
    v = w;
    for (int i = W - 1; i >= 0; i--) begin
      vn_valid = 1'b1;
      vn_bit = v[i];
      tick();
    end
    vn_valid = 1'b0;
    vn_bit = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic accept_word();
    seed_ready = 1'b1;
    tick();
    seed_ready = 1'b0;
  endtask

  int c0;
  int pv;
  int seen0;

  initial begin
    model_reset();
    #2;
    check("rst_vn_enable", vn_enable, 0);
    check("rst_seed_valid", seed_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_health", health_fail, 0);
    check("rst_data", seed_data, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    kick();
    send_word(8'hB2);
    check("b2_valid", seed_valid, 1);
    check("b2_data", seed_data, 8'hB2);
    check("b2_enable", vn_enable, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", seed_valid, 1);
      check("hold_data", seed_data, 8'hB2);
    end
    accept_word();
    check("ack_busy", busy, 0);

    seen0 = to_seen;
    kick();
    c0 = cyc_no;
    for (int i = 0; i < 20; i++) tick();
    check("to_count", to_seen - seen0, 1);
    check("to_cycle", to_cyc - c0, MC);
    check("to_enable", vn_enable, 0);
    check("to_busy", busy, 0);

    kick();
    send_word(8'hF0);
    check("hf_set", health_fail, 1);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("hf_hold", health_fail, 1);
    check("hf_enable", vn_enable, 0);
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    check("hf_clear", health_fail, 0);
    check("hf_busy", busy, 0);

    kick();
    for (int i = 0; i < 3; i++) begin
      vn_valid = 1'b1;
      vn_bit = i[0];
      tick();
    end
    vn_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_enable", vn_enable, 0);
    check("arst_data", seed_data, 0);
    tick();
    reset_n = 1'b1;
    kick();
    send_word(8'h5A);
    check("5a_data", seed_data, 8'h5A);

    start = 1'b1;
    accept_word();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_enable", vn_enable, 1);
    send_word(8'h96);
    check("b2b_data", seed_data, 8'h96);
    accept_word();

    seen0 = to_seen;
    kick();
    for (int i = 0; i < W; i++) tick();
    send_word(8'hB2);
    check("race_valid", seed_valid, 1);
    check("race_no_to", to_seen - seen0, 0);
    accept_word();

    kick();
    send_word(8'hAF);
    check("trip_wins_hf", health_fail, 1);
    check("trip_wins_sv", seed_valid, 0);
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;

    for (int seg = 0; seg < 30; seg++) begin
      pv = $urandom_range(5, 90);
      for (int i = 0; i < 100; i++) begin
        start      = ($urandom_range(0, 99) < 30);
        vn_valid   = ($urandom_range(0, 99) < pv);
        vn_bit     = $urandom_range(0, 1) == 1;
        seed_ready = ($urandom_range(0, 99) < 30);
        clear_fail = ($urandom_range(0, 99) < 20);
        if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
